// File: rtl/wbu_pkg.sv
// Shared types and constants for the writeback/commit unit.
// wbu_entry_t is the default-width layout of one queued instruction.
package wbu_pkg;

  localparam int XLEN_D   = 32;
  localparam int CSR_AW_D = 12;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  typedef struct packed {
    logic [XLEN_D-1:0]   pc;
    logic [4:0]          rd_id;
    logic                gpr_wen;
    logic [XLEN_D-1:0]   rd;
    logic                csr_wen;
    logic [CSR_AW_D-1:0] csr_wid;
    logic [XLEN_D-1:0]   csr_rd;
    logic                is_ecall;
    logic                is_mret;
    logic [XLEN_D-1:0]   mcause;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_commit_q_fifo.sv
// In-order synchronous FIFO with flush; head data reads as zero when empty.
// Flush discards all entries and any same-cycle push.
module wbu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_head];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_tail] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wbu_commit_q.sv
// Writeback/commit unit: queues completed instructions and retires one per
// cycle into GPR/CSR/npc write strobes, trap/mret events and a retire count.
module wbu_commit_q
  import wbu_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int CSR_AW = CSR_AW_D,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [4:0]        i_rd_id,
  input  logic              i_gpr_wen,
  input  logic [XLEN-1:0]   i_rd,
  input  logic              i_csr_wen,
  input  logic [CSR_AW-1:0] i_csr_wid,
  input  logic [XLEN-1:0]   i_csr_rd,
  input  logic              i_is_ecall,
  input  logic              i_is_mret,
  input  logic [XLEN-1:0]   i_mcause,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_gpr_wen,
  output logic [4:0]        o_rd_id,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_csr_wen,
  output logic [CSR_AW-1:0] o_csr_wid,
  output logic [XLEN-1:0]   o_csr_rd,
  output logic              o_npc_wen,
  output logic              o_trap,
  output logic [XLEN-1:0]   o_mepc_in,
  output logic [XLEN-1:0]   o_mcause_in,
  output logic              o_mret,
  output logic              o_cycle_end,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  // Same field order as wbu_entry_t, widths follow the instance parameters.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rd_id;
    logic              gpr_wen;
    logic [XLEN-1:0]   rd;
    logic              csr_wen;
    logic [CSR_AW-1:0] csr_wid;
    logic [XLEN-1:0]   csr_rd;
    logic              is_ecall;
    logic              is_mret;
    logic [XLEN-1:0]   mcause;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          w_in;
  entry_t          w_head;
  logic [EW-1:0]   w_head_bits;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_retire;
  logic            r_cycle_end;
  logic [CNT_W-1:0] r_retire_cnt;

  assign w_in = '{pc: i_pc, rd_id: i_rd_id, gpr_wen: i_gpr_wen, rd: i_rd,
                  csr_wen: i_csr_wen, csr_wid: i_csr_wid, csr_rd: i_csr_rd,
                  is_ecall: i_is_ecall, is_mret: i_is_mret, mcause: i_mcause};

  assign o_ready = (w_count != CW'(DEPTH));
  assign w_push  = i_valid & ~w_full;
  // Gating with rst_n keeps every strobe low in a reset cycle.
  assign w_retire = rst_n & ~w_empty & ~i_stall;

  wbu_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_retire),
    .i_flush (i_flush),
    .i_data  (w_in),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = entry_t'(w_head_bits);

  assign o_rd_id     = w_head.rd_id;
  assign o_rd        = w_head.rd;
  assign o_csr_wid   = w_head.csr_wid;
  assign o_csr_rd    = w_head.csr_rd;
  assign o_mepc_in   = w_head.pc;
  assign o_mcause_in = w_head.mcause;

  assign o_gpr_wen = w_retire & w_head.gpr_wen & (w_head.rd_id != GPR_ZERO);
  assign o_csr_wen = w_retire & w_head.csr_wen;
  assign o_npc_wen = w_retire;
  assign o_trap    = w_retire & w_head.is_ecall;
  assign o_mret    = w_retire & w_head.is_mret;

  // cycle_end resets high so the IFU starts its first fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_end  <= 1'b1;
      r_retire_cnt <= '0;
    end else begin
      r_cycle_end <= w_retire;
      if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_end  = r_cycle_end;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wbu_commit_q.sv
// Directed bench for wbu_commit_q: a cycle table of stimulus and expected
// head/strobe state, plus hand-written reset sequences.
module tb_wbu_commit_q;

  localparam int XLEN = 32, CSR_AW = 12, DEPTH = 2, CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, i_valid, o_ready;
  logic [XLEN-1:0]   i_pc, i_rd, i_csr_rd, i_mcause;
  logic [4:0]        i_rd_id;
  logic              i_gpr_wen, i_csr_wen, i_is_ecall, i_is_mret, i_stall, i_flush;
  logic [CSR_AW-1:0] i_csr_wid;
  logic              o_gpr_wen, o_csr_wen, o_npc_wen, o_trap, o_mret, o_cycle_end;
  logic [4:0]        o_rd_id;
  logic [XLEN-1:0]   o_rd, o_csr_rd, o_mepc_in, o_mcause_in;
  logic [CSR_AW-1:0] o_csr_wid;
  logic [CNT_W-1:0]  o_retire_cnt;

  wbu_commit_q #(.XLEN(XLEN), .CSR_AW(CSR_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rd_id(i_rd_id), .i_gpr_wen(i_gpr_wen), .i_rd(i_rd),
    .i_csr_wen(i_csr_wen), .i_csr_wid(i_csr_wid), .i_csr_rd(i_csr_rd),
    .i_is_ecall(i_is_ecall), .i_is_mret(i_is_mret), .i_mcause(i_mcause),
    .i_stall(i_stall), .i_flush(i_flush),
    .o_gpr_wen(o_gpr_wen), .o_rd_id(o_rd_id), .o_rd(o_rd),
    .o_csr_wen(o_csr_wen), .o_csr_wid(o_csr_wid), .o_csr_rd(o_csr_rd),
    .o_npc_wen(o_npc_wen), .o_trap(o_trap), .o_mepc_in(o_mepc_in),
    .o_mcause_in(o_mcause_in), .o_mret(o_mret), .o_cycle_end(o_cycle_end),
    .o_retire_cnt(o_retire_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_id;
    logic        gpr_wen;
    logic [31:0] rd;
    logic        csr_wen;
    logic [11:0] csr_wid;
    logic [31:0] csr_rd;
    logic        ecall;
    logic        mret;
    logic [31:0] mcause;
  } ent_t;

  // One row per cycle: inputs driven, then expected ready, retire, head, cycle_end.
  typedef struct {
    logic valid;
    logic stall;
    logic flush;
    ent_t in;
    logic ready;
    logic retire;
    ent_t head;
    logic ce;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic ent_t gpr(input logic [4:0] id, input logic [31:0] d);
    ent_t e = '0;
    e.rd_id = id; e.gpr_wen = 1'b1; e.rd = d;
    return e;
  endfunction

  function automatic vec_t v(input logic valid, input logic stall, input logic flush,
                             input ent_t in, input logic ready, input logic retire,
                             input ent_t head, input logic ce);
    vec_t r;
    r.valid = valid; r.stall = stall; r.flush = flush; r.in = in;
    r.ready = ready; r.retire = retire; r.head = head; r.ce = ce;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic stall, input logic flush, input ent_t e);
    i_valid = valid; i_stall = stall; i_flush = flush;
    i_pc = e.pc; i_rd_id = e.rd_id; i_gpr_wen = e.gpr_wen; i_rd = e.rd;
    i_csr_wen = e.csr_wen; i_csr_wid = e.csr_wid; i_csr_rd = e.csr_rd;
    i_is_ecall = e.ecall; i_is_mret = e.mret; i_mcause = e.mcause;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string t, input logic ready, input logic retire,
                               input ent_t h, input logic ce);
    chk({t, ".ready"},     o_ready,     ready);
    chk({t, ".npc_wen"},   o_npc_wen,   retire);
    chk({t, ".gpr_wen"},   o_gpr_wen,   retire & h.gpr_wen & (h.rd_id != 5'd0));
    chk({t, ".rd_id"},     o_rd_id,     h.rd_id);
    chk({t, ".rd"},        o_rd,        h.rd);
    chk({t, ".csr_wen"},   o_csr_wen,   retire & h.csr_wen);
    chk({t, ".csr_wid"},   o_csr_wid,   h.csr_wid);
    chk({t, ".csr_rd"},    o_csr_rd,    h.csr_rd);
    chk({t, ".trap"},      o_trap,      retire & h.ecall);
    chk({t, ".mepc"},      o_mepc_in,   h.pc);
    chk({t, ".mcause"},    o_mcause_in, h.mcause);
    chk({t, ".mret"},      o_mret,      retire & h.mret);
    chk({t, ".cycle_end"}, o_cycle_end, ce);
  endtask

  initial begin
    ent_t z, a, b, c, d, e, f, g, h0, ec, mr, cs, p1, p2, p3, q1, q2, w1, w2, w3, w4, r1, r2;
    z  = '0;
    a  = gpr(5'd1, 32'h11); b = gpr(5'd2, 32'h22); c = gpr(5'd3, 32'h33); d = gpr(5'd4, 32'h44);
    e  = gpr(5'd5, 32'h55); f = gpr(5'd6, 32'h66); g = gpr(5'd7, 32'h77);
    h0 = gpr(5'd0, 32'h99);
    ec = '0; ec.ecall = 1'b1; ec.pc = 32'h8000_0010; ec.mcause = 32'd11;
    mr = '0; mr.mret = 1'b1;
    cs = '0; cs.csr_wen = 1'b1; cs.csr_wid = 12'h300; cs.csr_rd = 32'h0000_ABCD;
    p1 = gpr(5'd8, 32'h88); p2 = gpr(5'd9, 32'h99); p3 = gpr(5'd10, 32'hAA);
    q1 = gpr(5'd12, 32'hC1); q2 = gpr(5'd13, 32'hC2);
    w1 = gpr(5'd11, 32'hB1); w2 = gpr(5'd11, 32'hB2); w3 = gpr(5'd11, 32'hB3); w4 = gpr(5'd11, 32'hB4);
    r1 = gpr(5'd14, 32'hD1); r2 = gpr(5'd15, 32'hD2);

    //               valid stall flush in   ready retire head ce
    // back-to-back push
    tbl.push_back(v(1, 0, 0, a,  1, 0, z,  0));
    tbl.push_back(v(1, 0, 0, b,  1, 1, a,  0));
    tbl.push_back(v(1, 0, 0, c,  1, 1, b,  1));
    tbl.push_back(v(1, 0, 0, d,  1, 1, c,  1));
    tbl.push_back(v(0, 0, 0, z,  1, 1, d,  1));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));
    // stall and fill
    tbl.push_back(v(1, 1, 0, e,  1, 0, z,  0));
    tbl.push_back(v(1, 1, 0, f,  1, 0, e,  0));
    tbl.push_back(v(1, 1, 0, g,  0, 0, e,  0));
    tbl.push_back(v(1, 0, 0, g,  0, 1, e,  0));
    tbl.push_back(v(1, 0, 0, g,  1, 1, f,  1));
    tbl.push_back(v(0, 0, 0, z,  1, 1, g,  1));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));
    // rd_id 0, ecall, mret, csr write
    tbl.push_back(v(1, 0, 0, h0, 1, 0, z,  0));
    tbl.push_back(v(1, 0, 0, ec, 1, 1, h0, 0));
    tbl.push_back(v(1, 0, 0, mr, 1, 1, ec, 1));
    tbl.push_back(v(1, 0, 0, cs, 1, 1, mr, 1));
    tbl.push_back(v(0, 0, 0, z,  1, 1, cs, 1));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));
    // flush with full queue, then flush with a same-cycle accepted push
    tbl.push_back(v(1, 1, 0, p1, 1, 0, z,  0));
    tbl.push_back(v(1, 1, 0, p2, 1, 0, p1, 0));
    tbl.push_back(v(1, 0, 1, p3, 0, 1, p1, 0));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));
    tbl.push_back(v(1, 1, 0, q1, 1, 0, z,  0));
    tbl.push_back(v(1, 0, 1, q2, 1, 1, q1, 0));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  0));
    // four more retires: 17 total wraps a 4-bit counter to 1
    tbl.push_back(v(1, 0, 0, w1, 1, 0, z,  0));
    tbl.push_back(v(1, 0, 0, w2, 1, 1, w1, 0));
    tbl.push_back(v(1, 0, 0, w3, 1, 1, w2, 1));
    tbl.push_back(v(1, 0, 0, w4, 1, 1, w3, 1));
    tbl.push_back(v(0, 0, 0, z,  1, 1, w4, 1));
    tbl.push_back(v(0, 0, 0, z,  1, 0, z,  1));

    // reset held for three edges
    rst_n = 1'b0;
    drive(0, 0, 0, z);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check_outputs($sformatf("rst%0d", i), 1'b1, 1'b0, z, 1'b1);
      chk($sformatf("rst%0d.cnt", i), o_retire_cnt, 0);
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_outputs("post_rst", 1'b1, 1'b0, z, 1'b0);
    chk("post_rst.cnt", o_retire_cnt, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      drive(tbl[i].valid, tbl[i].stall, tbl[i].flush, tbl[i].in);
      @(negedge clk);
      check_outputs($sformatf("v%0d", i), tbl[i].ready, tbl[i].retire, tbl[i].head, tbl[i].ce);
      if (i == 5)  chk("cnt_after_b2b",     o_retire_cnt, 4);
      if (i == 18) chk("cnt_after_special", o_retire_cnt, 11);
      if (i == 26) chk("cnt_after_flush",   o_retire_cnt, 13);
    end
    chk("cnt_wrap", o_retire_cnt, 1);

    // reset with two entries queued
    tick(); drive(1, 1, 0, r1);
    tick(); drive(1, 1, 0, r2);
    @(negedge clk);
    chk("mid.queued_head", o_rd_id, 14);
    tick(); drive(0, 0, 0, z); rst_n = 1'b0;
    @(negedge clk);
    chk("mid.rst_npc_wen", o_npc_wen, 0);
    chk("mid.rst_gpr_wen", o_gpr_wen, 0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check_outputs("mid.after_rst", 1'b1, 1'b0, z, 1'b1);
    chk("mid.after_rst.cnt", o_retire_cnt, 0);
    tick();
    @(negedge clk);
    check_outputs("mid.after_rst2", 1'b1, 1'b0, z, 1'b0);
    chk("mid.after_rst2.cnt", o_retire_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
